// File: rtl/apb_regbank_slave.sv
// APB4 slave with a flat-exported, byte-strobed register bank and programmable wait states.
// Optional macro APB_REGBANK_PSLVERR_EN routes decode/permission errors onto PSLVERR.
module apb_regbank_slave #(
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     ADDR_WIDTH  = 16,
   parameter logic [3:0]             SLAVE_ID    = 4'h1,
   parameter int                     NUM_REGS    = 16,
   parameter int                     WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   output logic                           PREADY,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

   localparam int         IDXW = $clog2(NUM_REGS);
   localparam int         NB   = DATA_WIDTH / 8;
   localparam logic [3:0] WS   = 4'(WAIT_STATES);

   // The setup phase is decoded while IDLE so the registered PREADY can rise in the first access cycle.
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [IDXW-1:0]         r_idx;
   logic                    r_write;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [NB-1:0]           r_strb;
   logic [3:0]              r_cnt;
   logic                    r_pready;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

   logic                    w_sel;
   logic                    w_setup;
   logic [IDXW-1:0]         w_idx_live;
   logic [ADDR_WIDTH-5:0]   w_mid;
   logic                    w_err_live;
   logic [IDXW-1:0]         w_rsp_idx;
   logic                    w_rsp_err;
   logic                    w_rsp_write;
   logic [DATA_WIDTH-1:0]   w_prdata_next;
   logic                    w_commit;

   assign w_sel      = PSEL && (PADDR[ADDR_WIDTH-1 -: 4] == SLAVE_ID);
   assign w_setup    = (r_state == S_IDLE) && w_sel && !PENABLE;
   assign w_idx_live = PADDR[2 +: IDXW];
   assign w_mid      = PADDR[ADDR_WIDTH-5:0];

   // Bits between the register index and the slave-ID nibble must be zero.
   assign w_err_live = (PADDR[1:0] != 2'b00)
                    || ((w_mid >> (2 + IDXW)) != '0)
                    || ({1'b0, w_idx_live} >= (IDXW+1)'(NUM_REGS))
                    || (PWRITE && RO_MASK[w_idx_live]);

   assign w_rsp_idx   = (r_state == S_IDLE) ? w_idx_live : r_idx;
   assign w_rsp_err   = (r_state == S_IDLE) ? w_err_live : r_err;
   assign w_rsp_write = (r_state == S_IDLE) ? PWRITE     : r_write;
   assign w_commit    = (r_state == S_READY) && r_write && !r_err;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_setup) w_state_next = (WS == 4'd0) ? S_READY : S_WAIT;
         end
         S_WAIT: begin
            if (!PSEL)              w_state_next = S_IDLE;
            else if (r_cnt == 4'd1) w_state_next = S_READY;
         end
         S_READY: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_prdata_next = '0;
      if (w_state_next == S_READY && !w_rsp_err && !w_rsp_write)
         w_prdata_next = r_regs[w_rsp_idx];
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state  <= S_IDLE;
         r_pready <= 1'b0;
         r_prdata <= '0;
         r_idx    <= '0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_wdata  <= '0;
         r_strb   <= '0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_next;
         r_pready <= (w_state_next == S_READY);
         r_prdata <= w_prdata_next;
         if (w_setup) begin
            r_idx   <= w_idx_live;
            r_write <= PWRITE;
            r_err   <= w_err_live;
            r_wdata <= PWDATA;
            r_strb  <= PSTRB;
            r_cnt   <= WS;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      end else if (w_commit) begin
         for (int b = 0; b < NB; b++)
            if (r_strb[b]) r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_export
         assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      end
   endgenerate

   assign PREADY = r_pready;
   assign PRDATA = r_prdata;

`ifdef APB_REGBANK_PSLVERR_EN
   logic r_pslverr;
   always_ff @(posedge PCLK) begin
      if (PRESET) r_pslverr <= 1'b0;
      else        r_pslverr <= (w_state_next == S_READY) && w_rsp_err;
   end
   assign PSLVERR = r_pslverr;
`else
   assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench: two slaves on one APB bus (ID 1 zero-wait, ID 3 three waits with register 2 read-only).
module tb_apb_regbank_slave;

`ifdef APB_REGBANK_PSLVERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   localparam logic [31:0] RV = 32'hA5A5_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  paddr;
   logic         psel, penable, pwrite;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic         pready0, pready1, pslverr0, pslverr1;
   logic [31:0]  prdata0, prdata1;
   logic [511:0] regq0, regq1;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int setup_cyc   = 0;

   typedef struct {
      int          dut;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   apb_regbank_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .SLAVE_ID(4'h1), .NUM_REGS(16),
      .WAIT_STATES(0), .RO_MASK(16'h0000), .RESET_VAL(RV)
   ) u_dut0 (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready0),
      .PRDATA(prdata0), .PSLVERR(pslverr0), .reg_q(regq0)
   );

   apb_regbank_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .SLAVE_ID(4'h3), .NUM_REGS(16),
      .WAIT_STATES(3), .RO_MASK(16'h0004), .RESET_VAL(RV)
   ) u_dut1 (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready1),
      .PRDATA(prdata1), .PSLVERR(pslverr1), .reg_q(regq1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   // Monitor: every PREADY pulse pops one expected response.
   always @(negedge clk) begin
      if (pready0 || pready1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pready: got pready0=%b pready1=%b expected none", pready0, pready1);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_which"}, {30'd0, pready1, pready0}, (mon_e.dut == 0) ? 32'd1 : 32'd2);
            chk({mon_e.name, "_lat"}, 32'(cyc - setup_cyc), 32'(mon_e.lat));
            chk({mon_e.name, "_prdata"}, (mon_e.dut == 0) ? prdata0 : prdata1, mon_e.rdata);
            chk({mon_e.name, "_pslverr"}, {31'd0, (mon_e.dut == 0) ? pslverr0 : pslverr1}, {31'd0, mon_e.err});
            $display("txn %s done: prdata0=%h prdata1=%h", mon_e.name, prdata0, prdata1);
         end
      end
   end

   task automatic apb(input int dut, input string name, input logic [15:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic ee);
      exp_t e;
      bit   done;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
      setup_cyc = cyc;
      e.dut = dut; e.rdata = er; e.err = ee; e.lat = (dut == 0) ? 1 : 4; e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if ((dut == 0) ? pready0 : pready1) done = 1'b1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got no PREADY expected PREADY within 20 cycles", name);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rst_q0_%0d", i), regq0[i*32 +: 32], RV);
         chk($sformatf("rst_q1_%0d", i), regq1[i*32 +: 32], RV);
      end
      chk("rst_out0", {pready0, pslverr0, 30'd0} | prdata0, 32'd0);
      chk("rst_out1", {pready1, pslverr1, 30'd0} | prdata1, 32'd0);
      @(posedge clk); #1;

      // Zero-wait slave: write/read back-to-back, then byte strobes.
      apb(0, "wr_1008", 16'h1008, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
      apb(0, "rd_1008", 16'h1008, 1'b0, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("q0_slice2", regq0[2*32 +: 32], 32'hDEAD_BEEF);
      chk("q0_slice0", regq0[0 +: 32], RV);
      @(posedge clk); #1;
      apb(0, "wr_strb", 16'h1008, 1'b1, 32'h1122_3344, 4'b0101, 32'd0, 1'b0);
      apb(0, "rd_strb", 16'h1008, 1'b0, 32'd0, 4'hF, 32'hDE22_BE44, 1'b0);
      @(negedge clk);
      chk("q0_strb", regq0[2*32 +: 32], 32'hDE22_BE44);
      @(posedge clk); #1;

      // Three-wait slave.
      apb(1, "wr_w3", 16'h300C, 1'b1, 32'h1234_5678, 4'hF, 32'd0, 1'b0);
      apb(1, "rd_w3", 16'h300C, 1'b0, 32'd0, 4'hF, 32'h1234_5678, 1'b0);
      @(negedge clk);
      chk("q1_slice3", regq1[3*32 +: 32], 32'h1234_5678);
      @(posedge clk); #1;

      // Error responses.
      apb(1, "err_ro", 16'h3008, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, EXP_ERR);
      apb(1, "err_unal", 16'h3041, 1'b0, 32'd0, 4'hF, 32'd0, EXP_ERR);
      apb(1, "err_bit6", 16'h3040, 1'b0, 32'd0, 4'hF, 32'd0, EXP_ERR);
      @(negedge clk);
      chk("q1_ro_kept", regq1[2*32 +: 32], RV);
      chk("q1_slice0_kept", regq1[0 +: 32], RV);
      @(posedge clk); #1;

      // Abort during WAIT.
      psel = 1'b1; penable = 1'b0; paddr = 16'h3010; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (pready1) seen = 1'b1;
      end
      chk("abort_pready", {31'd0, seen}, 32'd0);
      chk("abort_q1_slice4", regq1[4*32 +: 32], RV);
      @(posedge clk); #1;
      apb(1, "rd_after_abort", 16'h3010, 1'b0, 32'd0, 4'hF, RV, 1'b0);

      // Foreign slave ID.
      psel = 1'b1; penable = 1'b0; paddr = 16'h2008; pwrite = 1'b1; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (pready0 || pready1 || pslverr0 || pslverr1 || prdata0 != 0 || prdata1 != 0) seen = 1'b1;
      end
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      chk("foreign_outputs", {31'd0, seen}, 32'd0);
      chk("foreign_q0_slice2", regq0[2*32 +: 32], 32'hDE22_BE44);

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
